climate_setpoint_ctrl: RTL and testbench

Multi-zone setpoint and thermostat controller for the home-appliance control path. It sits between the debounced front-panel buttons and temperature/humidity sensors on one side, and the HVAC drivers, display and humidifier on the other. It holds one target temperature per zone, adjusted with press-and-hold auto-repeat, and drives a per-zone heat/cool/stop demand with hysteresis. It also produces a registered comfort level and the ultrasonic humidifier toggle.

---
 rtl/climate_setpoint_ctrl_pkg.sv | 50 +++++
 rtl/climate_setpoint_ctrl_if.sv | 30 +++
 rtl/climate_setpoint_ctrl_zone_hyst.sv | 49 ++++
 rtl/climate_setpoint_ctrl.sv | 151 +++++++++++++++
 tb/tb_climate_setpoint_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/climate_setpoint_ctrl_pkg.sv
// Shared encodings and comfort thresholds for the multi-zone setpoint/thermostat controller.
package climate_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_MANUAL = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        HCS_HEAT = 2'd0,
        HCS_COOL = 2'd1,
        HCS_STOP = 2'd2
    } hcs_e;

    typedef enum logic [1:0] {
        LEVEL0 = 2'd0,
        LEVEL1 = 2'd1,
        LEVEL2 = 2'd2,
        LEVEL3 = 2'd3
    } level_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DLY  = 2'd1,
        R_RPT  = 2'd2
    } rpt_state_e;

    // Bit positions inside the registered button vector
    localparam int BTN_UP   = 0;
    localparam int BTN_DN   = 1;
    localparam int BTN_SEL  = 2;
    localparam int BTN_MIST = 3;
    localparam int N_BTN    = 4;

    localparam int CMF0_T_LO = 24, CMF0_T_HI = 27, CMF0_H_LO = 40, CMF0_H_HI = 60;
    localparam int CMF1_T_LO = 22, CMF1_T_HI = 29, CMF1_H_LO = 30, CMF1_H_HI = 70;
    localparam int CMF2_T_LO = 20, CMF2_T_HI = 31, CMF2_H_LO = 20, CMF2_H_HI = 80;

    function automatic level_e comfort_level(input int t, input int h);
        if (t >= CMF0_T_LO && t <= CMF0_T_HI && h >= CMF0_H_LO && h <= CMF0_H_HI)
            return LEVEL0;
        if (t >= CMF1_T_LO && t <= CMF1_T_HI && h >= CMF1_H_LO && h <= CMF1_H_HI)
            return LEVEL1;
        if (t >= CMF2_T_LO && t <= CMF2_T_HI && h >= CMF2_H_LO && h <= CMF2_H_HI)
            return LEVEL2;
        return LEVEL3;
    endfunction

endpackage

// File: rtl/climate_setpoint_ctrl_if.sv
// Panel/sensor inputs and HVAC/display outputs of the setpoint controller.
interface climate_setpoint_ctrl_if #(
    parameter int N_ZONE = 4,
    parameter int T_W    = 8,
    parameter int SEL_W  = (N_ZONE > 1) ? $clog2(N_ZONE) : 1
);
    logic                    tick;
    logic                    btn_up;
    logic                    btn_dn;
    logic                    btn_sel;
    logic                    btn_mist;
    logic [1:0]              mode;
    logic [N_ZONE*T_W-1:0]   zone_temp;
    logic [7:0]              humidity;
    logic [N_ZONE*T_W-1:0]   target_temp;
    logic [2*N_ZONE-1:0]     hcs;
    logic [SEL_W-1:0]        sel_zone;
    logic [1:0]              level;
    logic                    ultrasonic_mode;

    modport master (
        output tick, btn_up, btn_dn, btn_sel, btn_mist, mode, zone_temp, humidity,
        input  target_temp, hcs, sel_zone, level, ultrasonic_mode
    );

    modport slave (
        input  tick, btn_up, btn_dn, btn_sel, btn_mist, mode, zone_temp, humidity,
        output target_temp, hcs, sel_zone, level, ultrasonic_mode
    );
endinterface

// File: rtl/climate_setpoint_ctrl_zone_hyst.sv
// One zone's heat/cool/stop demand with a hysteresis band around the setpoint.
module zone_hyst
    import climate_pkg::*;
#(
    parameter int T_W  = 8,
    parameter int HYST = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_force_stop,
    input  logic [T_W-1:0] i_temp,
    input  logic [T_W-1:0] i_target,
    output logic [1:0]     o_hcs
);
    localparam int W = T_W + 1;

    // One extra bit so that value+HYST cannot wrap
    logic [W-1:0] w_t, w_tgt, w_t_h, w_tgt_h;
    hcs_e         r_state, w_state_nxt;

    assign w_t     = {1'b0, i_temp};
    assign w_tgt   = {1'b0, i_target};
    assign w_t_h   = w_t + W'(HYST);
    assign w_tgt_h = w_tgt + W'(HYST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= HCS_STOP;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_force_stop) begin
            w_state_nxt = HCS_STOP;
        end else begin
            case (r_state)
                HCS_STOP: begin
                    if (w_t_h < w_tgt)      w_state_nxt = HCS_HEAT;
                    else if (w_t > w_tgt_h) w_state_nxt = HCS_COOL;
                end
                HCS_HEAT: if (w_t >= w_tgt) w_state_nxt = HCS_STOP;
                HCS_COOL: if (w_t <= w_tgt) w_state_nxt = HCS_STOP;
                default:  w_state_nxt = HCS_STOP;
            endcase
        end
    end

    assign o_hcs = r_state;
endmodule

// File: rtl/climate_setpoint_ctrl.sv
// Multi-zone setpoint controller: button auto-repeat, per-zone hysteresis, comfort level, humidifier toggle.
module climate_setpoint_ctrl
    import climate_pkg::*;
#(
    parameter int N_ZONE     = 4,
    parameter int T_W        = 8,
    parameter int T_MIN      = 18,
    parameter int T_MAX      = 35,
    parameter int T_RST      = 24,
    parameter int HYST       = 1,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    climate_setpoint_ctrl_if.slave  bus
);
    localparam int SEL_W   = (N_ZONE > 1) ? $clog2(N_ZONE) : 1;
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [N_BTN-1:0]              w_btn, r_btn_q, r_arm, w_press;
    logic [N_ZONE-1:0][T_W-1:0]    r_target, w_temp;
    logic [N_ZONE-1:0][1:0]        w_hcs;
    logic [SEL_W-1:0]              r_sel;
    logic                          r_mist;
    level_e                        r_level;
    rpt_state_e                    r_state, w_state_nxt;
    logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
    logic                          r_dir, w_dir_nxt, w_step;
    logic                          w_abort, w_hold;
    logic [T_W-1:0]                w_cur, w_step_val;

    assign w_btn  = {bus.btn_mist, bus.btn_sel, bus.btn_dn, bus.btn_up};
    assign w_temp = bus.zone_temp;

    // r_arm keeps a button that was already held through reset from counting as a press
    assign w_press = w_btn & ~r_btn_q & r_arm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_q <= '0;
            r_arm   <= '0;
        end else begin
            r_btn_q <= w_btn;
            r_arm   <= r_arm | ~w_btn;
        end
    end

    assign w_hold  = r_dir ? bus.btn_up : bus.btn_dn;
    assign w_abort = (bus.mode != MODE_MANUAL) || (bus.btn_up && bus.btn_dn) || w_press[BTN_SEL];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!w_abort && (w_press[BTN_UP] || w_press[BTN_DN])) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = w_press[BTN_UP];
                    w_state_nxt = R_DLY;
                    w_cnt_nxt   = '0;
                end
            end
            R_DLY: begin
                if (w_abort || !w_hold) begin
                    w_state_nxt = R_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.tick) begin
                    if (r_cnt == CNT_W'(REPEAT_DLY - 1)) begin
                        w_step      = 1'b1;
                        w_state_nxt = R_RPT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            R_RPT: begin
                if (w_abort || !w_hold) begin
                    w_state_nxt = R_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.tick) begin
                    if (r_cnt == CNT_W'(REPEAT_PER - 1)) begin
                        w_step    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = R_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_cur      = r_target[r_sel];
    assign w_step_val = w_dir_nxt ? ((w_cur >= T_W'(T_MAX)) ? w_cur : w_cur + T_W'(1))
                                  : ((w_cur <= T_W'(T_MIN)) ? w_cur : w_cur - T_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target <= {N_ZONE{T_W'(T_RST)}};
            r_sel    <= '0;
            r_mist   <= 1'b0;
            r_level  <= LEVEL3;
        end else begin
            if (w_step) r_target[r_sel] <= w_step_val;
            if (w_press[BTN_SEL])
                r_sel <= (r_sel == SEL_W'(N_ZONE - 1)) ? '0 : r_sel + SEL_W'(1);
            if (w_press[BTN_MIST]) r_mist <= ~r_mist;
            r_level <= comfort_level(int'(w_temp[r_sel]), int'(bus.humidity));
        end
    end

    for (genvar z = 0; z < N_ZONE; z++) begin : g_zone
        zone_hyst #(
            .T_W  (T_W),
            .HYST (HYST)
        ) u_hyst (
            .clk          (clk),
            .reset        (reset),
            .i_force_stop (bus.mode == MODE_IDLE),
            .i_temp       (w_temp[z]),
            .i_target     (r_target[z]),
            .o_hcs        (w_hcs[z])
        );
    end

    assign bus.target_temp     = r_target;
    assign bus.hcs             = w_hcs;
    assign bus.sel_zone        = r_sel;
    assign bus.level           = r_level;
    assign bus.ultrasonic_mode = r_mist;
endmodule

// File: tb/tb_climate_setpoint_ctrl.sv
// Directed plus randomized bench for climate_setpoint_ctrl against a cycle-level behavioural model.
module tb_climate_setpoint_ctrl;
    localparam int NZ = 4, TMIN = 18, TMAX = 35, TRST = 24, HY = 1, DLY = 5, PER = 2;
    localparam int HEAT = 0, COOL = 1, STOP = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    climate_setpoint_ctrl_if #(.N_ZONE(NZ), .T_W(8)) bus ();

    climate_setpoint_ctrl #(
        .N_ZONE(NZ), .T_W(8), .T_MIN(TMIN), .T_MAX(TMAX), .T_RST(TRST),
        .HYST(HY), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model state
    int m_tgt[NZ], m_hcs[NZ], tmp[NZ];
    int m_sel, m_lvl, m_ticks;
    bit m_mist, m_held, m_hdir;
    bit m_prev[4], m_arm[4];

    function automatic int comfort(int t, int h);
        if (t >= 24 && t <= 27 && h >= 40 && h <= 60) return 0;
        if (t >= 22 && t <= 29 && h >= 30 && h <= 70) return 1;
        if (t >= 20 && t <= 31 && h >= 20 && h <= 80) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        for (int z = 0; z < NZ; z++) begin m_tgt[z] = TRST; m_hcs[z] = STOP; end
        m_sel = 0; m_lvl = 3; m_mist = 0; m_held = 0; m_hdir = 0; m_ticks = 0;
        for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_arm[i] = 0; end
    endfunction

    function automatic void do_step();
        if (m_hdir) m_tgt[m_sel] = (m_tgt[m_sel] + 1 > TMAX) ? TMAX : m_tgt[m_sel] + 1;
        else        m_tgt[m_sel] = (m_tgt[m_sel] - 1 < TMIN) ? TMIN : m_tgt[m_sel] - 1;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    function automatic void model_step();
        bit lv[4], pr[4];
        int t, tg, md;
        lv[0] = bus.btn_up; lv[1] = bus.btn_dn; lv[2] = bus.btn_sel; lv[3] = bus.btn_mist;
        md = int'(bus.mode);
        for (int i = 0; i < 4; i++) pr[i] = lv[i] && !m_prev[i] && m_arm[i];
        m_lvl = comfort(int'(bus.zone_temp[m_sel*8 +: 8]), int'(bus.humidity));
        for (int z = 0; z < NZ; z++) begin
            t = int'(bus.zone_temp[z*8 +: 8]);
            tg = m_tgt[z];
            if (md == 0) m_hcs[z] = STOP;
            else if (m_hcs[z] == STOP) begin
                if (t + HY < tg) m_hcs[z] = HEAT;
                else if (t > tg + HY) m_hcs[z] = COOL;
            end else if (m_hcs[z] == HEAT) begin
                if (t >= tg) m_hcs[z] = STOP;
            end else begin
                if (t <= tg) m_hcs[z] = STOP;
            end
        end
        if (md != 2 || (lv[0] && lv[1]) || pr[2] || (m_held && !(m_hdir ? lv[0] : lv[1]))) begin
            m_held = 0;
        end else if (!m_held) begin
            if (pr[0] || pr[1]) begin
                m_held = 1; m_hdir = pr[0]; m_ticks = 0; do_step();
            end
        end else if (bus.tick) begin
            m_ticks++;
            if (m_ticks == DLY || (m_ticks > DLY && (m_ticks - DLY) % PER == 0)) do_step();
        end
        if (pr[2]) m_sel = (m_sel + 1) % NZ;
        if (pr[3]) m_mist = !m_mist;
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = lv[i];
            if (!lv[i]) m_arm[i] = 1;
        end
    endfunction

    task automatic check_all();
        logic [31:0] et;
        logic [7:0]  eh;
        for (int z = 0; z < NZ; z++) begin
            et[z*8 +: 8] = 8'(m_tgt[z]);
            eh[z*2 +: 2] = 2'(m_hcs[z]);
        end
        chk("target", bus.target_temp, et);
        chk("hcs", bus.hcs, eh);
        chk("sel", bus.sel_zone, m_sel);
        chk("level", bus.level, m_lvl);
        chk("mist", bus.ultrasonic_mode, m_mist);
    endtask

    task automatic apply_temps();
        for (int z = 0; z < NZ; z++) bus.zone_temp[z*8 +: 8] = 8'(tmp[z]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic press(input int b);
        case (b)
            0: bus.btn_up = 1; 1: bus.btn_dn = 1; 2: bus.btn_sel = 1; default: bus.btn_mist = 1;
        endcase
        cyc();
        case (b)
            0: bus.btn_up = 0; 1: bus.btn_dn = 0; 2: bus.btn_sel = 0; default: bus.btn_mist = 0;
        endcase
        cyc();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tgt"}, bus.target_temp, 32'h18181818);
        chk({tag, "_hcs"}, bus.hcs, 8'hAA);
        chk({tag, "_sel"}, bus.sel_zone, 0);
        chk({tag, "_lvl"}, bus.level, 3);
        chk({tag, "_mist"}, bus.ultrasonic_mode, 0);
    endtask

    initial begin
        bus.tick = 0; bus.btn_up = 0; bus.btn_dn = 0; bus.btn_sel = 0; bus.btn_mist = 0;
        bus.mode = 2'd0; bus.humidity = 8'd50;
        for (int z = 0; z < NZ; z++) tmp[z] = 24;
        apply_temps();
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 0;

        // Single press in MANUAL
        bus.mode = 2'd2;
        cyc(); cyc();
        bus.btn_up = 1; cyc();
        chk("t1_z0", bus.target_temp[7:0], 25);
        chk("t1_other", bus.target_temp[31:8], 24'h181818);
        bus.btn_up = 0; cyc();

        // Auto-repeat up to saturation
        for (int i = 0; i < 8; i++) press(0);
        chk("t2_33", bus.target_temp[7:0], 33);
        bus.btn_up = 1; cyc();
        chk("t2_34", bus.target_temp[7:0], 34);
        for (int k = 1; k <= 9; k++) begin
            bus.tick = 1; cyc();
            bus.tick = 0; cyc();
            if (k == 4) chk("t2_pre5", bus.target_temp[7:0], 34);
            if (k == 5) chk("t2_tick5", bus.target_temp[7:0], 35);
        end
        chk("t2_sat", bus.target_temp[7:0], 35);
        bus.btn_up = 0; cyc();

        // Zone select and wrap
        for (int i = 0; i < 3; i++) press(2);
        chk("t3_sel3", bus.sel_zone, 3);
        press(1);
        chk("t3_z3", bus.target_temp[31:24], 23);
        press(2);
        chk("t3_wrap", bus.sel_zone, 0);

        // Hysteresis on zone 1 (target 24)
        bus.mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            logic [9:0] exp_seq;
            exp_seq = {2'(HEAT), 2'(HEAT), 2'(STOP), 2'(STOP), 2'(COOL)};
            tmp[1] = 22 + i; apply_temps(); cyc();
            chk("t4_hyst", bus.hcs[3:2], exp_seq[(4-i)*2 +: 2]);
        end

        // IDLE forces STOP; AUTO ignores up/down
        tmp[1] = 22; apply_temps(); cyc(); cyc();
        chk("t5_heat", bus.hcs[3:2], HEAT);
        bus.mode = 2'd0; cyc();
        chk("t5_idle", bus.hcs[3:2], STOP);
        bus.mode = 2'd1;
        press(2);
        press(0);
        chk("t5_auto", bus.target_temp[15:8], 24);

        // Both buttons, comfort level, mist
        bus.mode = 2'd2;
        bus.btn_up = 1; bus.btn_dn = 1; cyc(); cyc();
        chk("t6_both", bus.target_temp[15:8], 24);
        bus.btn_up = 0; bus.btn_dn = 0; cyc();
        tmp[1] = 25; apply_temps(); bus.humidity = 8'd50; cyc();
        chk("t6_lvl0", bus.level, 0);
        bus.humidity = 8'd75; cyc();
        chk("t6_lvl2", bus.level, 2);
        bus.btn_mist = 1; cyc();
        chk("t6_mist", bus.ultrasonic_mode, 1);
        bus.btn_mist = 0; cyc();

        // Reset in the middle of a hold
        bus.btn_up = 1; cyc();
        chk("t7_z1", bus.target_temp[15:8], 25);
        for (int i = 0; i < 3; i++) begin bus.tick = 1; cyc(); bus.tick = 0; cyc(); end
        reset = 1; #1;
        chk_reset_vals("midrst");
        model_reset();
        @(negedge clk); reset = 0;
        for (int i = 0; i < 10; i++) begin bus.tick = 1'(i % 2); cyc(); end
        bus.tick = 0;
        chk("t7_noprs", bus.target_temp[7:0], 24);
        bus.btn_up = 0; cyc();
        bus.btn_up = 1; cyc();
        chk("t7_reprs", bus.target_temp[7:0], 25);
        bus.btn_up = 0; cyc();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(39) == 0) begin
                int r;
                r = int'($urandom_range(99));
                bus.mode = (r < 60) ? 2'd2 : (r < 85) ? 2'd1 : 2'd0;
            end
            if ($urandom_range(7) == 0) bus.btn_up = ~bus.btn_up;
            if ($urandom_range(7) == 0) bus.btn_dn = ~bus.btn_dn;
            if ($urandom_range(29) == 0) bus.btn_sel = ~bus.btn_sel;
            if ($urandom_range(29) == 0) bus.btn_mist = ~bus.btn_mist;
            bus.tick = ($urandom_range(2) == 0);
            if ($urandom_range(3) == 0) begin
                for (int z = 0; z < NZ; z++) tmp[z] = m_tgt[z] + int'($urandom_range(6)) - 3;
                apply_temps();
            end
            if ($urandom_range(15) == 0) bus.humidity = 8'($urandom_range(100));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
